// File: rtl/l2_request_queue_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | l2_request_queue_pkg : shared L2 request packet definitions          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package l2_request_queue_pkg;

    localparam int NUM_CORES     = 4;
    localparam int CORE_ID_WIDTH = $clog2(NUM_CORES);

    typedef enum logic [1:0] {
        L2_OP_LOAD  = 2'd0,
        L2_OP_STORE = 2'd1,
        L2_OP_FLUSH = 2'd2,
        L2_OP_IINV  = 2'd3
    } l2_op_t;

    typedef struct packed {
        logic [CORE_ID_WIDTH-1:0] core_id;
        l2_op_t                   op;
        logic [31:0]              addr;
        logic [7:0]               tag;
    } l2req_packet_t;

endpackage
`default_nettype wire

// File: rtl/l2_request_queue_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_fifo : generic FIFO with registered full/empty and count        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_valid_i,
    input  logic [WIDTH-1:0]       wr_data_i,
    output logic                   wr_ready_o,
    output logic                   rd_valid_o,
    output logic [WIDTH-1:0]       rd_data_o,
    input  logic                   rd_ready_i,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int              PW      = $clog2(DEPTH);
    localparam int              CW      = PW + 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             w_enq, w_deq;

    // Handshakes qualify only on registered flags, so neither side sees a
    // combinational path from the other.
    assign w_enq = wr_valid_i && !full_q;
    assign w_deq = rd_ready_i && !empty_q;

    always_comb begin
        wr_ptr_d = w_enq ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = w_deq ? rd_ptr_q + PW'(1) : rd_ptr_q;
        case ({w_enq, w_deq})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == DEPTH_C);
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign wr_ready_o = !full_q;
    assign rd_valid_o = !empty_q;
    assign rd_data_o  = mem_q[rd_ptr_q];
    assign count_o    = count_q;

`ifndef SYNTHESIS
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("sync_fifo: DEPTH must be a power of two and at least 2");
    end

    always @(posedge clk) begin
        if (!reset) begin
            assert (!(w_enq && full_q)) else $error("sync_fifo: enqueue while full");
            assert (count_q <= DEPTH_C) else $error("sync_fifo: count exceeds DEPTH");
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/l2_request_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | l2_request_queue : per-core L2 request buffer ahead of the arbiter   |
// | Optional stats outputs: L2_REQUEST_QUEUE_STATS_EN. Revision: 1.0     |
// +----------------------------------------------------------------------+
module l2_request_queue
    import l2_request_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   core_request_valid,
    input  l2req_packet_t          core_request,
    output logic                   core_request_ready,
    output logic                   l2i_request_valid,
    output l2req_packet_t          l2i_request,
    input  logic                   l2_ready,
    output logic [$clog2(DEPTH):0] queue_count
`ifdef L2_REQUEST_QUEUE_STATS_EN
    ,
    output logic [31:0]            stat_full_cycles,
    output logic [$clog2(DEPTH):0] stat_high_water
`endif
);

    localparam int PKT_W = $bits(l2req_packet_t);

    logic [PKT_W-1:0] w_head;

    sync_fifo #(
        .WIDTH (PKT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .wr_valid_i (core_request_valid),
        .wr_data_i  (core_request),
        .wr_ready_o (core_request_ready),
        .rd_valid_o (l2i_request_valid),
        .rd_data_o  (w_head),
        .rd_ready_i (l2_ready),
        .count_o    (queue_count)
    );

    assign l2i_request = l2req_packet_t'(w_head);

`ifdef L2_REQUEST_QUEUE_STATS_EN
    localparam int            CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [31:0]   full_cycles_q, full_cycles_d;
    logic [CW-1:0] high_water_q, high_water_d;

    // Full-cycle counter counts core stalls (full with a pending request).
    always_comb begin
        full_cycles_d = full_cycles_q;
        if (queue_count == DEPTH_C && core_request_valid && full_cycles_q != '1) begin
            full_cycles_d = full_cycles_q + 32'd1;
        end
        high_water_d = (queue_count > high_water_q) ? queue_count : high_water_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full_cycles_q <= '0;
            high_water_q  <= '0;
        end else begin
            full_cycles_q <= full_cycles_d;
            high_water_q  <= high_water_d;
        end
    end

    assign stat_full_cycles = full_cycles_q;
    assign stat_high_water  = high_water_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_l2_request_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_l2_request_queue : directed + random bench with a queue model     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_l2_request_queue;
    import l2_request_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int PKW   = $bits(l2req_packet_t);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          core_request_valid = 1'b0;
    l2req_packet_t core_request = '0;
    logic          l2_ready = 1'b0;
    logic          core_request_ready;
    logic          l2i_request_valid;
    l2req_packet_t l2i_request;
    logic [CW-1:0] queue_count;
`ifdef L2_REQUEST_QUEUE_STATS_EN
    logic [31:0]   stat_full_cycles;
    logic [CW-1:0] stat_high_water;
`endif

    int checks = 0;
    int errors = 0;

    l2req_packet_t model_q[$];
    logic [7:0]    popped[$];
    int            m_full_cycles = 0;
    int            m_high_water  = 0;

    l2_request_queue #(.DEPTH(DEPTH)) dut (
        .clk                (clk),
        .reset              (reset),
        .core_request_valid (core_request_valid),
        .core_request       (core_request),
        .core_request_ready (core_request_ready),
        .l2i_request_valid  (l2i_request_valid),
        .l2i_request        (l2i_request),
        .l2_ready           (l2_ready),
        .queue_count        (queue_count)
`ifdef L2_REQUEST_QUEUE_STATS_EN
        ,
        .stat_full_cycles   (stat_full_cycles),
        .stat_high_water    (stat_high_water)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string when);
        chk({when, "_valid"}, 64'(l2i_request_valid), 64'(model_q.size() != 0));
        chk({when, "_ready"}, 64'(core_request_ready), 64'(model_q.size() < DEPTH));
        chk({when, "_count"}, 64'(queue_count), 64'(model_q.size()));
        if (model_q.size() != 0) begin
            chk({when, "_head"}, 64'(l2i_request), 64'(model_q[0]));
        end
`ifdef L2_REQUEST_QUEUE_STATS_EN
        chk({when, "_stat_full"}, 64'(stat_full_cycles), 64'(m_full_cycles));
        chk({when, "_stat_hw"}, 64'(stat_high_water), 64'(m_high_water));
`endif
    endtask

    function automatic l2req_packet_t mk(input logic [7:0] tag);
        logic [PKW-1:0] raw;
        l2req_packet_t  p;
        raw = PKW'({$urandom, $urandom});
        p = raw;
        p.tag = tag;
        return p;
    endfunction

    // One clock: inputs change after the previous edge, outputs are checked
    // before the edge (must not react to the new inputs) and after it.
    task automatic cycle(input logic vld, input l2req_packet_t pkt, input logic rdy);
        int sz;
        bit enq, deq;
        core_request_valid = vld;
        core_request       = pkt;
        l2_ready           = rdy;
        #1;
        check_state("pre");
        sz  = model_q.size();
        enq = vld && (sz < DEPTH);
        deq = rdy && (sz > 0);
        @(posedge clk);
        if (sz == DEPTH && vld) m_full_cycles++;
        if (sz > m_high_water) m_high_water = sz;
        if (deq) begin
            popped.push_back(model_q[0].tag);
            void'(model_q.pop_front());
        end
        if (enq) model_q.push_back(pkt);
        #1;
        check_state("post");
    endtask

    task automatic apply_reset();
        core_request_valid = 1'b0;
        l2_ready           = 1'b0;
        reset              = 1'b1;
        #1;
        chk("rst_async_valid", 64'(l2i_request_valid), 64'(0));
        chk("rst_async_ready", 64'(core_request_ready), 64'(1));
        chk("rst_async_count", 64'(queue_count), 64'(0));
        model_q.delete();
        popped.delete();
        m_full_cycles = 0;
        m_high_water  = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_state("rst_done");
    endtask

    task automatic chk_popped(input string tag, input int first, input int n);
        chk({tag, "_n"}, 64'(popped.size()), 64'(n));
        for (int i = 0; i < n && i < popped.size(); i++) begin
            chk({tag, "_order"}, 64'(popped[i]), 64'(first + i));
        end
    endtask

    initial begin
        #2;
        apply_reset();

        // Idle, then l2_ready while empty must be ignored.
        repeat (2) cycle(1'b0, mk(8'h00), 1'b0);
        repeat (2) cycle(1'b0, mk(8'h00), 1'b1);
        chk("idle_count", 64'(queue_count), 64'(0));

        // Head visible one cycle after enqueue and stable while stalled.
        cycle(1'b1, mk(8'hA0), 1'b0);
        chk("lat_valid", 64'(l2i_request_valid), 64'(1));
        chk("lat_head", 64'(l2i_request.tag), 64'(8'hA0));
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, mk(8'hFF), 1'b0);
            chk("hold_head", 64'(l2i_request.tag), 64'(8'hA0));
        end
        cycle(1'b0, mk(8'hFF), 1'b1);
        chk("lat_drained", 64'(l2i_request_valid), 64'(0));

        // Fill to DEPTH, reject E, one dequeue, then E accepted; order 1..5.
        popped.delete();
        for (int i = 1; i <= 4; i++) cycle(1'b1, mk(8'(i)), 1'b0);
        chk("full_ready", 64'(core_request_ready), 64'(0));
        chk("full_count", 64'(queue_count), 64'(4));
        cycle(1'b1, mk(8'd5), 1'b0);
        cycle(1'b1, mk(8'd5), 1'b1);
        chk("full_deq_count", 64'(queue_count), 64'(3));
        chk("full_reassert", 64'(core_request_ready), 64'(1));
        cycle(1'b1, mk(8'd5), 1'b0);
        repeat (6) cycle(1'b0, mk(8'hFF), 1'b1);
        chk_popped("full", 1, 5);

        // Streaming at count 1: pointers wrap twice with no loss.
        popped.delete();
        cycle(1'b1, mk(8'd0), 1'b0);
        for (int i = 1; i < 10; i++) begin
            cycle(1'b1, mk(8'(i)), 1'b1);
            chk("stream_count", 64'(queue_count), 64'(1));
        end
        cycle(1'b0, mk(8'hFF), 1'b1);
        chk_popped("stream", 0, 10);

        // Reset with three entries queued discards them.
        for (int i = 0; i < 3; i++) cycle(1'b1, mk(8'(8'h30 + i)), 1'b0);
        chk("pre_rst_count", 64'(queue_count), 64'(3));
        apply_reset();
        cycle(1'b1, mk(8'h58), 1'b0);
        chk("post_rst_head", 64'(l2i_request.tag), 64'(8'h58));
        cycle(1'b0, mk(8'hFF), 1'b1);

`ifdef L2_REQUEST_QUEUE_STATS_EN
        apply_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, mk(8'(i)), 1'b0);
        for (int i = 0; i < 7; i++) cycle(1'b1, mk(8'h77), 1'b0);
        chk("stat_full_7", 64'(stat_full_cycles), 64'(7));
        chk("stat_hw_4", 64'(stat_high_water), 64'(4));
        repeat (5) cycle(1'b0, mk(8'hFF), 1'b1);
`endif

        // Random traffic: first biased towards full, then towards empty.
        for (int i = 0; i < 300; i++) begin
            logic v, r;
            if (i < 150) begin
                v = ($urandom_range(0, 99) < 75);
                r = ($urandom_range(0, 99) < 40);
            end else begin
                v = ($urandom_range(0, 99) < 40);
                r = ($urandom_range(0, 99) < 75);
            end
            cycle(v, mk(8'(i)), r);
        end
        repeat (DEPTH + 1) cycle(1'b0, mk(8'hFF), 1'b1);
        chk("final_empty", 64'(l2i_request_valid), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
